// File: rtl/lsu_pkg.sv
// Shared types and geometry helpers for the load/store alignment engine.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

   function automatic int bus_bytes(input int bus_width);
      return bus_width / 8;
   endfunction

   function automatic int off_w(input int bus_width);
      return $clog2(bus_width / 8);
   endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// Data-bus beat channel: request with handshake, response always accepted.
interface lsu_align_unit_if #(
   parameter int BUS_WIDTH  = 64,
   parameter int ADDR_WIDTH = 64
);
   logic                   bus_req_valid;
   logic                   bus_req_ready;
   logic [ADDR_WIDTH-1:0]  bus_req_addr;
   logic                   bus_req_wen;
   logic [BUS_WIDTH/8-1:0] bus_req_wstrb;
   logic [BUS_WIDTH-1:0]   bus_req_wdata;
   logic                   bus_resp_valid;
   logic [BUS_WIDTH-1:0]   bus_resp_rdata;
   logic                   bus_resp_err;

   modport master (
      output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata,
      input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
   );

   modport slave (
      input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata,
      output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
   );
endinterface

// File: rtl/lsu_lane_shift.sv
// Byte-lane steering: two-beat store data/strobes and merged, extended load result.
module lsu_lane_shift
   import lsu_pkg::*;
#(
   parameter int  XLEN      = 64,
   parameter int  BUS_WIDTH = 64,
   localparam int BUS_BYTES = bus_bytes(BUS_WIDTH),
   localparam int OFF_W     = off_w(BUS_WIDTH)
) (
   input  logic [OFF_W-1:0]     off,
   input  size_e                size,
   input  logic                 uext,
   input  logic [XLEN-1:0]      wdata,
   input  logic [BUS_WIDTH-1:0] beat0,
   input  logic [BUS_WIDTH-1:0] beat1,
   output logic [BUS_WIDTH-1:0] wdata0,
   output logic [BUS_WIDTH-1:0] wdata1,
   output logic [BUS_BYTES-1:0] wstrb0,
   output logic [BUS_BYTES-1:0] wstrb1,
   output logic [XLEN-1:0]      rdata_ext
);
   localparam int XBYTES = XLEN / 8;
   localparam int WIDE   = 2 * BUS_WIDTH;

   logic [3:0]             nbytes;
   logic [OFF_W+2:0]       bit_off;
   logic [XLEN-1:0]        wdata_m;
   logic [2*BUS_BYTES-1:0] strb_base;
   logic [WIDE-1:0]        wide_data;
   logic [2*BUS_BYTES-1:0] wide_strb;
   logic [WIDE-1:0]        cat_data;
   logic [XLEN-1:0]        raw;
   logic                   sign_bit;
   logic                   ext_bit;

   assign nbytes  = 4'd1 << size;
   assign bit_off = {off, 3'b000};

   always_comb begin
      wdata_m   = '0;
      strb_base = '0;
      for (int i = 0; i < XBYTES; i++) begin
         if (i < int'(nbytes)) wdata_m[i*8 +: 8] = wdata[i*8 +: 8];
      end
      for (int i = 0; i < 8; i++) begin
         if (i < int'(nbytes)) strb_base[i] = 1'b1;
      end
   end

   // Store payload spans two bus words; the low half is beat 0, the high half beat 1.
   assign wide_data        = {{(WIDE-XLEN){1'b0}}, wdata_m} << bit_off;
   assign wide_strb        = strb_base << off;
   assign {wdata1, wdata0} = wide_data;
   assign {wstrb1, wstrb0} = wide_strb;

   assign cat_data = {beat1, beat0};

   always_comb begin
      raw = '0;
      for (int i = 0; i < XBYTES; i++) begin
         raw[i*8 +: 8] = cat_data[(int'(off) + i)*8 +: 8];
      end
   end

   always_comb begin
      case (size)
         SZ_B:    sign_bit = raw[7];
         SZ_H:    sign_bit = raw[15];
         SZ_W:    sign_bit = raw[31];
         default: sign_bit = raw[XLEN-1];
      endcase
      ext_bit   = sign_bit & ~uext;
      rdata_ext = '0;
      for (int i = 0; i < XBYTES; i++) begin
         rdata_ext[i*8 +: 8] = (i < int'(nbytes)) ? raw[i*8 +: 8] : {8{ext_bit}};
      end
   end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment engine: splits bus-word-crossing accesses into two beats,
// merging loads and byte-strobing stores between the core and the data bus.
//
// state | meaning
// IDLE  | ready for a core request
// REQ0  | presenting beat 0 to the bus
// WAIT0 | waiting for beat 0 response
// REQ1  | presenting beat 1 (split access only)
// WAIT1 | waiting for beat 1 response
// RESP  | one-cycle core response
module lsu_align_unit
   import lsu_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int BUS_WIDTH      = 64,
   parameter int ALLOW_MISALIGN = 1,
   parameter int ADDR_WIDTH     = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  core_req_valid,
   output logic                  core_req_ready,
   input  logic [ADDR_WIDTH-1:0] core_req_addr,
   input  logic [1:0]            core_req_size,
   input  logic                  core_req_wen,
   input  logic                  core_req_uext,
   input  logic [XLEN-1:0]       core_req_wdata,
   output logic                  core_resp_valid,
   output logic [XLEN-1:0]       core_resp_rdata,
   output logic                  core_resp_err,
   lsu_align_unit_if.master      bus
);
   localparam int BUS_BYTES = bus_bytes(BUS_WIDTH);
   localparam int OFF_W     = off_w(BUS_WIDTH);

   state_e                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   size_e                 size_q;
   logic                  wen_q;
   logic                  uext_q;
   logic                  split_q;
   logic                  err_q;
   logic [XLEN-1:0]       wdata_q;
   logic [XLEN-1:0]       rdata_q;
   logic [BUS_WIDTH-1:0]  beat0_q;

   logic [OFF_W-1:0]      req_off;
   logic [3:0]            req_nbytes;
   logic                  req_split;
   logic                  req_err;
   logic                  accept;
   logic                  beat_done;

   logic [ADDR_WIDTH-1:0] beat0_addr;
   logic [ADDR_WIDTH-1:0] beat1_addr;
   logic [BUS_WIDTH-1:0]  ls_beat0;
   logic [BUS_WIDTH-1:0]  ls_beat1;
   logic [BUS_WIDTH-1:0]  ls_wdata0;
   logic [BUS_WIDTH-1:0]  ls_wdata1;
   logic [BUS_BYTES-1:0]  ls_wstrb0;
   logic [BUS_BYTES-1:0]  ls_wstrb1;
   logic [XLEN-1:0]       ls_rdata;

   assign req_off    = core_req_addr[OFF_W-1:0];
   assign req_nbytes = 4'd1 << core_req_size;
   assign req_split  = (int'(req_off) + int'(req_nbytes)) > BUS_BYTES;
   assign req_err    = ((core_req_size == SZ_D) && (XLEN == 32)) ||
                       ((ALLOW_MISALIGN == 0) &&
                        ((core_req_addr[2:0] & (req_nbytes[2:0] - 3'd1)) != 3'd0));

   assign accept    = (state == ST_IDLE) && core_req_valid;
   assign beat_done = bus.bus_resp_valid && ((state == ST_WAIT0) || (state == ST_WAIT1));

   assign beat0_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   assign beat1_addr = beat0_addr + ADDR_WIDTH'(BUS_BYTES);

   // Live response data feeds the merge so the result can register on the final beat.
   assign ls_beat0 = (state == ST_WAIT0) ? bus.bus_resp_rdata : beat0_q;
   assign ls_beat1 = (state == ST_WAIT1) ? bus.bus_resp_rdata : '0;

   lsu_lane_shift #(
      .XLEN      (XLEN),
      .BUS_WIDTH (BUS_WIDTH)
   ) u_lane_shift (
      .off       (addr_q[OFF_W-1:0]),
      .size      (size_q),
      .uext      (uext_q),
      .wdata     (wdata_q),
      .beat0     (ls_beat0),
      .beat1     (ls_beat1),
      .wdata0    (ls_wdata0),
      .wdata1    (ls_wdata1),
      .wstrb0    (ls_wstrb0),
      .wstrb1    (ls_wstrb1),
      .rdata_ext (ls_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt         = state;
      core_req_ready    = 1'b0;
      core_resp_valid   = 1'b0;
      bus.bus_req_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            core_req_ready = 1'b1;
            if (core_req_valid) state_nxt = req_err ? ST_RESP : ST_REQ0;
         end
         ST_REQ0: begin
            bus.bus_req_valid = 1'b1;
            if (bus.bus_req_ready) state_nxt = ST_WAIT0;
         end
         ST_WAIT0: begin
            if (bus.bus_resp_valid)
               state_nxt = (split_q && !bus.bus_resp_err) ? ST_REQ1 : ST_RESP;
         end
         ST_REQ1: begin
            bus.bus_req_valid = 1'b1;
            if (bus.bus_req_ready) state_nxt = ST_WAIT1;
         end
         ST_WAIT1: begin
            if (bus.bus_resp_valid) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            core_resp_valid = 1'b1;
            state_nxt       = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.bus_req_addr  = '0;
      bus.bus_req_wen   = 1'b0;
      bus.bus_req_wstrb = '0;
      bus.bus_req_wdata = '0;
      if (state == ST_REQ0) begin
         bus.bus_req_addr  = beat0_addr;
         bus.bus_req_wen   = wen_q;
         bus.bus_req_wstrb = wen_q ? ls_wstrb0 : '0;
         bus.bus_req_wdata = wen_q ? ls_wdata0 : '0;
      end else if (state == ST_REQ1) begin
         bus.bus_req_addr  = beat1_addr;
         bus.bus_req_wen   = wen_q;
         bus.bus_req_wstrb = wen_q ? ls_wstrb1 : '0;
         bus.bus_req_wdata = wen_q ? ls_wdata1 : '0;
      end
   end

   assign core_resp_rdata = (state == ST_RESP) ? rdata_q : '0;
   assign core_resp_err   = (state == ST_RESP) && err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         size_q  <= SZ_B;
         wen_q   <= 1'b0;
         uext_q  <= 1'b0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         beat0_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= core_req_addr;
            size_q  <= size_e'(core_req_size);
            wen_q   <= core_req_wen;
            uext_q  <= core_req_uext;
            wdata_q <= core_req_wdata;
            split_q <= req_split;
            err_q   <= req_err;
            rdata_q <= '0;
         end
         if ((state == ST_WAIT0) && bus.bus_resp_valid) beat0_q <= bus.bus_resp_rdata;
         // A split beat-0 result is provisional; the beat-1 merge overwrites it.
         if (beat_done) begin
            err_q   <= err_q | bus.bus_resp_err;
            rdata_q <= (wen_q || bus.bus_resp_err) ? '0 : ls_rdata;
         end
      end
   end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: one misalign-capable and one strict-alignment instance.
module tb_lsu_align_unit;

   logic clk;
   logic rst_n;

   logic        core_a_valid, core_a_ready, core_a_wen, core_a_uext;
   logic [63:0] core_a_addr, core_a_wdata, core_a_resp_rdata;
   logic [1:0]  core_a_size;
   logic        core_a_resp_valid, core_a_resp_err;

   logic        core_b_valid, core_b_ready, core_b_wen, core_b_uext;
   logic [63:0] core_b_addr, core_b_wdata, core_b_resp_rdata;
   logic [1:0]  core_b_size;
   logic        core_b_resp_valid, core_b_resp_err;

   lsu_align_unit_if #(.BUS_WIDTH(64), .ADDR_WIDTH(64)) bus_a ();
   lsu_align_unit_if #(.BUS_WIDTH(64), .ADDR_WIDTH(64)) bus_b ();

   lsu_align_unit #(.XLEN(64), .BUS_WIDTH(64), .ALLOW_MISALIGN(1), .ADDR_WIDTH(64)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .core_req_valid(core_a_valid), .core_req_ready(core_a_ready),
      .core_req_addr(core_a_addr), .core_req_size(core_a_size),
      .core_req_wen(core_a_wen), .core_req_uext(core_a_uext), .core_req_wdata(core_a_wdata),
      .core_resp_valid(core_a_resp_valid), .core_resp_rdata(core_a_resp_rdata),
      .core_resp_err(core_a_resp_err),
      .bus(bus_a)
   );

   lsu_align_unit #(.XLEN(64), .BUS_WIDTH(64), .ALLOW_MISALIGN(0), .ADDR_WIDTH(64)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .core_req_valid(core_b_valid), .core_req_ready(core_b_ready),
      .core_req_addr(core_b_addr), .core_req_size(core_b_size),
      .core_req_wen(core_b_wen), .core_req_uext(core_b_uext), .core_req_wdata(core_b_wdata),
      .core_resp_valid(core_b_resp_valid), .core_resp_rdata(core_b_resp_rdata),
      .core_resp_err(core_b_resp_err),
      .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet_a(input string tag);
      chk({tag, "_req_ready"},  core_a_ready, 1'b1);
      chk({tag, "_resp_valid"}, core_a_resp_valid, 1'b0);
      chk({tag, "_resp_rdata"}, core_a_resp_rdata, 64'h0);
      chk({tag, "_resp_err"},   core_a_resp_err, 1'b0);
      chk({tag, "_bus_valid"},  bus_a.bus_req_valid, 1'b0);
      chk({tag, "_bus_addr"},   bus_a.bus_req_addr, 64'h0);
      chk({tag, "_bus_wen"},    bus_a.bus_req_wen, 1'b0);
      chk({tag, "_bus_wstrb"},  bus_a.bus_req_wstrb, 8'h0);
      chk({tag, "_bus_wdata"},  bus_a.bus_req_wdata, 64'h0);
   endtask

   task automatic issue(input logic [63:0] addr, input logic [1:0] size, input logic wen,
                        input logic uext, input logic [63:0] wdata);
      chk("issue_req_ready", core_a_ready, 1'b1);
      core_a_valid = 1'b1;
      core_a_addr  = addr;
      core_a_size  = size;
      core_a_wen   = wen;
      core_a_uext  = uext;
      core_a_wdata = wdata;
      @(negedge clk);
      core_a_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input logic [63:0] addr, input logic wen,
                              input logic [7:0] wstrb, input logic [63:0] wdata);
      int n = 0;
      while (bus_a.bus_req_valid !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req_seen"}, (n < 16), 1'b1);
      chk({tag, "_addr"},  bus_a.bus_req_addr, addr);
      chk({tag, "_wen"},   bus_a.bus_req_wen, wen);
      chk({tag, "_wstrb"}, bus_a.bus_req_wstrb, wstrb);
      chk({tag, "_wdata"}, bus_a.bus_req_wdata, wdata);
      @(negedge clk);
      chk({tag, "_valid_drop"}, bus_a.bus_req_valid, 1'b0);
   endtask

   task automatic give_resp(input logic [63:0] rdata, input logic err);
      bus_a.bus_resp_valid = 1'b1;
      bus_a.bus_resp_rdata = rdata;
      bus_a.bus_resp_err   = err;
      @(negedge clk);
      bus_a.bus_resp_valid = 1'b0;
      bus_a.bus_resp_rdata = '0;
      bus_a.bus_resp_err   = 1'b0;
   endtask

   task automatic expect_resp(input string tag, input logic [63:0] rdata, input logic err);
      chk({tag, "_resp_valid"}, core_a_resp_valid, 1'b1);
      chk({tag, "_resp_rdata"}, core_a_resp_rdata, rdata);
      chk({tag, "_resp_err"},   core_a_resp_err, err);
      chk({tag, "_req_ready_in_resp"}, core_a_ready, 1'b0);
      @(negedge clk);
      chk({tag, "_resp_pulse_end"}, core_a_resp_valid, 1'b0);
      chk({tag, "_ready_again"},    core_a_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      core_a_valid = 0; core_a_addr = '0; core_a_size = '0; core_a_wen = 0; core_a_uext = 0; core_a_wdata = '0;
      core_b_valid = 0; core_b_addr = '0; core_b_size = '0; core_b_wen = 0; core_b_uext = 0; core_b_wdata = '0;
      bus_a.bus_req_ready = 1'b1; bus_a.bus_resp_valid = 1'b0; bus_a.bus_resp_rdata = '0; bus_a.bus_resp_err = 1'b0;
      bus_b.bus_req_ready = 1'b1; bus_b.bus_resp_valid = 1'b0; bus_b.bus_resp_rdata = '0; bus_b.bus_resp_err = 1'b0;
      repeat (2) @(negedge clk);
      chk_quiet_a("reset");
      chk("reset_b_ready", core_b_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Strict-alignment instance: misaligned LH errors without touching the bus.
      core_b_valid = 1'b1; core_b_addr = 64'h1001; core_b_size = 2'd1;
      @(negedge clk);
      core_b_valid = 1'b0;
      chk("b_mis_resp_valid", core_b_resp_valid, 1'b1);
      chk("b_mis_resp_err",   core_b_resp_err, 1'b1);
      chk("b_mis_resp_rdata", core_b_resp_rdata, 64'h0);
      chk("b_mis_no_bus",     bus_b.bus_req_valid, 1'b0);
      @(negedge clk);
      chk("b_mis_pulse_end",  core_b_resp_valid, 1'b0);
      chk("b_mis_no_bus2",    bus_b.bus_req_valid, 1'b0);
      // Aligned LH on the strict instance proceeds normally.
      core_b_valid = 1'b1; core_b_addr = 64'h1002; core_b_size = 2'd1;
      @(negedge clk);
      core_b_valid = 1'b0;
      chk("b_lh_req_valid", bus_b.bus_req_valid, 1'b1);
      chk("b_lh_req_addr",  bus_b.bus_req_addr, 64'h1000);
      @(negedge clk);
      bus_b.bus_resp_valid = 1'b1; bus_b.bus_resp_rdata = 64'h00000000_12340000;
      @(negedge clk);
      bus_b.bus_resp_valid = 1'b0;
      chk("b_lh_resp_valid", core_b_resp_valid, 1'b1);
      chk("b_lh_resp_rdata", core_b_resp_rdata, 64'h1234);
      chk("b_lh_resp_err",   core_b_resp_err, 1'b0);
      @(negedge clk);

      // LW sign-extended, minimum latency.
      issue(64'h1004, 2'd2, 1'b0, 1'b0, 64'h0);
      expect_beat("lw", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h89ABCDEF_01234567, 1'b0);
      expect_resp("lw", 64'hFFFFFFFF_89ABCDEF, 1'b0);

      // Split LD across two bus words.
      issue(64'h1006, 2'd3, 1'b0, 1'b0, 64'h0);
      expect_beat("ld_b0", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h11223344_55667788, 1'b0);
      expect_beat("ld_b1", 64'h1008, 1'b0, 8'h00, 64'h0);
      give_resp(64'h99AABBCC_DDEEFF00, 1'b0);
      expect_resp("ld_split", 64'hBBCCDDEE_FF001122, 1'b0);

      // Split SW; upper store bits must be masked off.
      issue(64'h100E, 2'd2, 1'b1, 1'b0, 64'h12345678_AABBCCDD);
      expect_beat("sw_b0", 64'h1008, 1'b1, 8'hC0, 64'hCCDD0000_00000000);
      give_resp(64'hDEADBEEF_DEADBEEF, 1'b0);
      expect_beat("sw_b1", 64'h1010, 1'b1, 8'h03, 64'h00000000_0000AABB);
      give_resp(64'hDEADBEEF_DEADBEEF, 1'b0);
      expect_resp("sw", 64'h0, 1'b0);

      // Misaligned LH on the permissive instance: single beat, signed then unsigned.
      issue(64'h1001, 2'd1, 1'b0, 1'b0, 64'h0);
      expect_beat("lh", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h00000000_0080FF00, 1'b0);
      expect_resp("lh", 64'hFFFFFFFF_FFFF80FF, 1'b0);
      issue(64'h1001, 2'd1, 1'b0, 1'b1, 64'h0);
      expect_beat("lhu", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h00000000_0080FF00, 1'b0);
      expect_resp("lhu", 64'h00000000_000080FF, 1'b0);

      // LB from the top lane.
      issue(64'h1007, 2'd0, 1'b0, 1'b0, 64'h0);
      expect_beat("lb", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h85000000_00000000, 1'b0);
      expect_resp("lb", 64'hFFFFFFFF_FFFFFF85, 1'b0);

      // Bus error on beat 0 of a split load: no second beat.
      issue(64'h1006, 2'd3, 1'b0, 1'b0, 64'h0);
      expect_beat("lderr_b0", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h11111111_11111111, 1'b1);
      chk("lderr_no_beat1", bus_a.bus_req_valid, 1'b0);
      expect_resp("lderr", 64'h0, 1'b1);

      // Stalled SD: payload held while ready is low; stray response in REQ0 ignored.
      bus_a.bus_req_ready = 1'b0;
      issue(64'h2000, 2'd3, 1'b1, 1'b0, 64'h01234567_89ABCDEF);
      bus_a.bus_resp_valid = 1'b1; bus_a.bus_resp_err = 1'b1; bus_a.bus_resp_rdata = '1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", bus_a.bus_req_valid, 1'b1);
         chk("stall_addr",  bus_a.bus_req_addr, 64'h2000);
         chk("stall_wstrb", bus_a.bus_req_wstrb, 8'hFF);
         chk("stall_wdata", bus_a.bus_req_wdata, 64'h01234567_89ABCDEF);
         @(negedge clk);
         bus_a.bus_resp_valid = 1'b0; bus_a.bus_resp_err = 1'b0; bus_a.bus_resp_rdata = '0;
      end
      bus_a.bus_req_ready = 1'b1;
      expect_beat("sd_stall", 64'h2000, 1'b1, 8'hFF, 64'h01234567_89ABCDEF);
      give_resp(64'h0, 1'b0);
      expect_resp("sd_stall", 64'h0, 1'b0);

      // Beat 1 address wraps past the top of the address space.
      issue(64'hFFFFFFFF_FFFFFFFC, 2'd3, 1'b0, 1'b0, 64'h0);
      expect_beat("wrap_b0", 64'hFFFFFFFF_FFFFFFF8, 1'b0, 8'h00, 64'h0);
      give_resp(64'hDDCCBBAA_00000000, 1'b0);
      expect_beat("wrap_b1", 64'h0, 1'b0, 8'h00, 64'h0);
      give_resp(64'h00000000_44332211, 1'b0);
      expect_resp("ld_wrap", 64'h44332211_DDCCBBAA, 1'b0);

      // Reset while waiting on beat 1 abandons the access silently.
      issue(64'h1006, 2'd3, 1'b0, 1'b0, 64'h0);
      expect_beat("rst_b0", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h11223344_55667788, 1'b0);
      expect_beat("rst_b1", 64'h1008, 1'b0, 8'h00, 64'h0);
      rst_n = 1'b0;
      #1;
      chk_quiet_a("rst_wait1");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_resp", core_a_resp_valid, 1'b0);
         chk("post_rst_ready",   core_a_ready, 1'b1);
      end

      // Stray response in IDLE is ignored; LWU afterwards is clean.
      bus_a.bus_resp_valid = 1'b1; bus_a.bus_resp_err = 1'b1;
      @(negedge clk);
      bus_a.bus_resp_valid = 1'b0; bus_a.bus_resp_err = 1'b0;
      issue(64'h1000, 2'd2, 1'b0, 1'b1, 64'h0);
      expect_beat("lwu", 64'h1000, 1'b0, 8'h00, 64'h0);
      give_resp(64'h89ABCDEF_F1234567, 1'b0);
      expect_resp("lwu", 64'h00000000_F1234567, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
